// File: rtl/approx_mult_pipe.sv
// approx_mult_pipe: three-stage pipelined approximate multiplier.
//
// Each operand is split into two halves, giving four half-width partial products.
// Each product can be truncated (low TRUNC bits cleared) under its own per-transaction
// approx bit. The products are then merged by an exact add, an OR, or a hybrid combiner.
// S1 captures the operands, S2 forms the partial products, and S3 combines them and is
// the output register. Valid/ready on both sides, with full backpressure.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake
//   in_a, in_b          unsigned operands (WIDTH bits)
//   in_mode             combiner: 0 add, 1 OR, 2 hybrid, 3 same as add
//   in_approx           truncate enables: bit0 LL, bit1 LH, bit2 HL, bit3 HH
//   in_tag              sideband returned with the result
//   out_valid/out_ready output handshake
//   out_r, out_tag      product (2*WIDTH bits) and its tag
//   op_count            saturating count of output handshakes
module approx_mult_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned TRUNC = 2,
  parameter int unsigned TAG_W = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [1:0]         in_mode,
  input  logic [3:0]         in_approx,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_r,
  output logic [TAG_W-1:0]   out_tag,
  output logic [CNT_W-1:0]   op_count
);

  localparam int unsigned H  = WIDTH / 2;
  localparam int unsigned RW = 2 * WIDTH;

  logic s1_valid_q, s2_valid_q, s3_valid_q;
  logic s1_en, s2_en, s3_en;

  // A stage may load when it is empty or its contents move on this edge.
  assign s3_en    = !s3_valid_q || out_ready;
  assign s2_en    = !s2_valid_q || s3_en;
  assign s1_en    = !s1_valid_q || s2_en;
  assign in_ready = s1_en;

  // S1: operand capture
  logic [WIDTH-1:0] s1_a_q, s1_b_q;
  logic [1:0]       s1_mode_q;
  logic [3:0]       s1_approx_q;
  logic [TAG_W-1:0] s1_tag_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_mode_q   <= '0;
      s1_approx_q <= '0;
      s1_tag_q    <= '0;
    end else if (s1_en) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_a_q      <= in_a;
        s1_b_q      <= in_b;
        s1_mode_q   <= in_mode;
        s1_approx_q <= in_approx;
        s1_tag_q    <= in_tag;
      end
    end
  end

  // S2: partial products, index order LL, LH, HL, HH matches the approx bits
  logic [WIDTH-1:0] trunc_mask;
  logic [WIDTH-1:0] pp_raw [4];
  logic [WIDTH-1:0] pp_d   [4];
  logic [WIDTH-1:0] s2_pp_q [4];
  logic [1:0]       s2_mode_q;
  logic [TAG_W-1:0] s2_tag_q;

  assign trunc_mask = {WIDTH{1'b1}} << TRUNC;

  always_comb begin
    pp_raw[0] = WIDTH'(s1_a_q[H-1:0])     * WIDTH'(s1_b_q[H-1:0]);
    pp_raw[1] = WIDTH'(s1_a_q[H-1:0])     * WIDTH'(s1_b_q[WIDTH-1:H]);
    pp_raw[2] = WIDTH'(s1_a_q[WIDTH-1:H]) * WIDTH'(s1_b_q[H-1:0]);
    pp_raw[3] = WIDTH'(s1_a_q[WIDTH-1:H]) * WIDTH'(s1_b_q[WIDTH-1:H]);
    for (int q = 0; q < 4; q++) begin
      pp_d[q] = s1_approx_q[q] ? (pp_raw[q] & trunc_mask) : pp_raw[q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      for (int q = 0; q < 4; q++) s2_pp_q[q] <= '0;
      s2_mode_q  <= '0;
      s2_tag_q   <= '0;
    end else if (s2_en) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        for (int q = 0; q < 4; q++) s2_pp_q[q] <= pp_d[q];
        s2_mode_q <= s1_mode_q;
        s2_tag_q  <= s1_tag_q;
      end
    end
  end

  // S3: combine into the output register
  logic [RW-1:0]  ll_ext, lh_sh, hl_sh, hh_sh, mid_sh, r_d;
  logic [WIDTH:0] mid_sum;
  logic [RW-1:0]  s3_r_q;
  logic [TAG_W-1:0] s3_tag_q;

  always_comb begin
    ll_ext  = RW'(s2_pp_q[0]);
    lh_sh   = RW'(s2_pp_q[1]) << H;
    hl_sh   = RW'(s2_pp_q[2]) << H;
    hh_sh   = RW'(s2_pp_q[3]) << WIDTH;
    // Hybrid mode adds the two middle products exactly, one carry bit wider.
    mid_sum = {1'b0, s2_pp_q[1]} + {1'b0, s2_pp_q[2]};
    mid_sh  = RW'(mid_sum) << H;
    case (s2_mode_q)
      2'd1:    r_d = ll_ext | lh_sh | hl_sh | hh_sh;
      2'd2:    r_d = mid_sh | ll_ext | hh_sh;
      default: r_d = ll_ext + lh_sh + hl_sh + hh_sh;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_valid_q <= 1'b0;
      s3_r_q     <= '0;
      s3_tag_q   <= '0;
    end else if (s3_en) begin
      s3_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        s3_r_q   <= r_d;
        s3_tag_q <= s2_tag_q;
      end
    end
  end

  assign out_valid = s3_valid_q;
  assign out_r     = s3_r_q;
  assign out_tag   = s3_tag_q;

  // Completed-operation counter, sticks at all-ones
  logic [CNT_W-1:0] op_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count_q <= '0;
    end else if (s3_valid_q && out_ready && (op_count_q != {CNT_W{1'b1}})) begin
      op_count_q <= op_count_q + CNT_W'(1);
    end
  end

  assign op_count = op_count_q;

endmodule
